// File: rtl/fetch_stage_if.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_stage_if
//  Description : Bundle of the handshake and bus signals around the IF stage
//                and its IF/ID register. The fetch stage connects through the
//                slave modport; the surrounding pipeline (or a bench) drives
//                through the master modport.
//  Signals     : stall_i, is_branch_d_i, branch_taken_i, branch_target_i,
//                exc_req_i, eret_i, epc_i, imem_rdata_i  (into the stage)
//                imem_addr_o, instr_d_o, imm16_d_o, pc_d_o, pc8_d_o, bd_d_o,
//                exccode_d_o, valid_d_o                  (out of the stage)
//  Revision    : 1.0 - initial release
// ============================================================================
interface fetch_stage_if;
    logic        stall_i;
    logic        is_branch_d_i;
    logic        branch_taken_i;
    logic [31:0] branch_target_i;
    logic        exc_req_i;
    logic        eret_i;
    logic [31:0] epc_i;
    logic [31:0] imem_addr_o;
    logic [31:0] imem_rdata_i;
    logic [31:0] instr_d_o;
    logic [15:0] imm16_d_o;
    logic [31:0] pc_d_o;
    logic [31:0] pc8_d_o;
    logic        bd_d_o;
    logic [4:0]  exccode_d_o;
    logic        valid_d_o;

    modport slave (
        input  stall_i, is_branch_d_i, branch_taken_i, branch_target_i,
               exc_req_i, eret_i, epc_i, imem_rdata_i,
        output imem_addr_o, instr_d_o, imm16_d_o, pc_d_o, pc8_d_o,
               bd_d_o, exccode_d_o, valid_d_o
    );

    modport master (
        output stall_i, is_branch_d_i, branch_taken_i, branch_target_i,
               exc_req_i, eret_i, epc_i, imem_rdata_i,
        input  imem_addr_o, instr_d_o, imm16_d_o, pc_d_o, pc8_d_o,
               bd_d_o, exccode_d_o, valid_d_o
    );
endinterface
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_stage
//  Description : IF stage plus IF/ID pipeline register of the P7 MIPS
//                pipeline. Holds the fetch PC, addresses the combinational
//                instruction memory, checks the fetch address (AdEL) and
//                latches instruction, PC, PC+8, delay-slot flag and fetch
//                exception code for decode.
//  Ports       : clk   - clock, rising edge
//                reset - asynchronous, active-low (0 = in reset)
//                bus   - fetch_stage_if.slave: redirect/stall controls in,
//                        instruction memory address/data, IF/ID outputs
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_3000,
    parameter logic [31:0] EXC_ENTRY = 32'h0000_4180,
    parameter logic [31:0] IM_BASE   = 32'h0000_3000,
    parameter logic [31:0] IM_WORDS  = 32'd4096
) (
    input  wire logic         clk,
    input  wire logic         reset,
    fetch_stage_if.slave      bus
);

    localparam logic [4:0]  c_EXC_NONE = 5'd0;
    localparam logic [4:0]  c_EXC_ADEL = 5'd4;
    // End address computed in 34 bits so a memory ending at 2^32 cannot wrap.
    localparam logic [33:0] c_IM_END   = {2'b00, IM_BASE} + {IM_WORDS, 2'b00};

    logic [31:0] r_pc_f;
    logic [31:0] r_instr_d;
    logic [31:0] r_pc_d;
    logic        r_bd_d;
    logic [4:0]  r_exccode_d;
    logic        r_valid_d;

    logic        w_adel;
    logic [31:0] w_fetch_instr;
    logic [4:0]  w_fetch_exc;
    logic [31:0] w_pc_f_nxt;
    logic [31:0] w_instr_nxt;
    logic [31:0] w_pc_d_nxt;
    logic        w_bd_nxt;
    logic [4:0]  w_exccode_nxt;
    logic        w_valid_nxt;

    // Fetch address check on the current PC.
    always_comb begin
        w_adel = (r_pc_f[1:0] != 2'b00)
              || ({2'b00, r_pc_f} <  {2'b00, IM_BASE})
              || ({2'b00, r_pc_f} >= c_IM_END);
        // A faulting fetch is turned into a nop carrying the AdEL code.
        w_fetch_instr = w_adel ? 32'h0 : bus.imem_rdata_i;
        w_fetch_exc   = w_adel ? c_EXC_ADEL : c_EXC_NONE;
    end

    // Next-state selection, highest priority first.
    always_comb begin
        w_pc_f_nxt    = r_pc_f;
        w_instr_nxt   = r_instr_d;
        w_pc_d_nxt    = r_pc_d;
        w_bd_nxt      = r_bd_d;
        w_exccode_nxt = r_exccode_d;
        w_valid_nxt   = r_valid_d;
        if (bus.exc_req_i || bus.eret_i) begin
            // Both flush IF/ID; exception entry wins over eret on the PC.
            w_pc_f_nxt    = bus.exc_req_i ? EXC_ENTRY : bus.epc_i;
            w_instr_nxt   = 32'h0;
            w_pc_d_nxt    = 32'h0;
            w_bd_nxt      = 1'b0;
            w_exccode_nxt = c_EXC_NONE;
            w_valid_nxt   = 1'b0;
        end else if (!bus.stall_i) begin
            // A stalled taken branch is dropped here; decode re-asserts it.
            w_pc_f_nxt    = bus.branch_taken_i ? bus.branch_target_i
                                               : r_pc_f + 32'd4;
            w_instr_nxt   = w_fetch_instr;
            w_pc_d_nxt    = r_pc_f;
            // Any branch in D, taken or not, marks the fetched word as its slot.
            w_bd_nxt      = bus.branch_taken_i | bus.is_branch_d_i;
            w_exccode_nxt = w_fetch_exc;
            w_valid_nxt   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc_f      <= RESET_PC;
            r_instr_d   <= 32'h0;
            r_pc_d      <= 32'h0;
            r_bd_d      <= 1'b0;
            r_exccode_d <= c_EXC_NONE;
            r_valid_d   <= 1'b0;
        end else begin
            r_pc_f      <= w_pc_f_nxt;
            r_instr_d   <= w_instr_nxt;
            r_pc_d      <= w_pc_d_nxt;
            r_bd_d      <= w_bd_nxt;
            r_exccode_d <= w_exccode_nxt;
            r_valid_d   <= w_valid_nxt;
        end
    end

    assign bus.imem_addr_o = r_pc_f;
    assign bus.instr_d_o   = r_instr_d;
    assign bus.imm16_d_o   = r_instr_d[15:0];
    assign bus.pc_d_o      = r_pc_d;
    assign bus.pc8_d_o     = r_pc_d + 32'd8;
    assign bus.bd_d_o      = r_bd_d;
    assign bus.exccode_d_o = r_exccode_d;
    assign bus.valid_d_o   = r_valid_d;

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_stage
//  Description : Self-checking bench for fetch_stage: directed vector table,
//                asynchronous reset in the middle of a stall, and a random
//                phase checked against a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    fetch_stage_if bus ();

    fetch_stage #(
        .RESET_PC  (32'h0000_3000),
        .EXC_ENTRY (32'h0000_4180),
        .IM_BASE   (32'h0000_3000),
        .IM_WORDS  (32'd4096)
    ) u_dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory contents: a fixed, address-dependent pattern.
    function automatic logic [31:0] imem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0F0F;
    endfunction

    assign bus.imem_rdata_i = imem_word(bus.imem_addr_o);

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h @%0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_outs(input string tag, input logic [31:0] addr,
                              input logic [31:0] instr, input logic [31:0] pcd,
                              input logic bd, input logic [4:0] exc, input logic valid);
        cmp({tag, ".imem_addr"}, bus.imem_addr_o, addr);
        cmp({tag, ".instr"},     bus.instr_d_o, instr);
        cmp({tag, ".imm16"},     {16'h0, bus.imm16_d_o}, {16'h0, instr[15:0]});
        cmp({tag, ".pc_d"},      bus.pc_d_o, pcd);
        cmp({tag, ".pc8"},       bus.pc8_d_o, pcd + 32'd8);
        cmp({tag, ".bd"},        {31'h0, bus.bd_d_o}, {31'h0, bd});
        cmp({tag, ".exccode"},   {27'h0, bus.exccode_d_o}, {27'h0, exc});
        cmp({tag, ".valid"},     {31'h0, bus.valid_d_o}, {31'h0, valid});
    endtask

    task automatic drive(input logic st, input logic isb, input logic tk,
                         input logic [31:0] tgt, input logic ex, input logic er,
                         input logic [31:0] epc);
        bus.stall_i         = st;
        bus.is_branch_d_i   = isb;
        bus.branch_taken_i  = tk;
        bus.branch_target_i = tgt;
        bus.exc_req_i       = ex;
        bus.eret_i          = er;
        bus.epc_i           = epc;
    endtask

    // ---------------- behavioural reference model ----------------
    logic [31:0] m_pc, m_instr, m_pcd;
    logic        m_bd, m_valid;
    logic [4:0]  m_exc;

    task automatic model_reset();
        m_pc = 32'h3000; m_instr = 0; m_pcd = 0; m_bd = 0; m_exc = 0; m_valid = 0;
    endtask

    task automatic model_step();
        bit bad;
        bad = (m_pc % 4 != 0) || (m_pc < 32'h3000) || (m_pc >= 32'h3000 + 4 * 4096);
        if (bus.exc_req_i) begin
            m_pc = 32'h4180;
            m_instr = 0; m_pcd = 0; m_bd = 0; m_exc = 0; m_valid = 0;
        end else if (bus.eret_i) begin
            m_pc = bus.epc_i;
            m_instr = 0; m_pcd = 0; m_bd = 0; m_exc = 0; m_valid = 0;
        end else if (bus.stall_i) begin
            // everything holds
        end else begin
            m_instr = bad ? 32'h0 : imem_word(m_pc);
            m_exc   = bad ? 5'd4 : 5'd0;
            m_pcd   = m_pc;
            m_valid = 1;
            if (bus.branch_taken_i) begin
                m_bd = 1;
                m_pc = bus.branch_target_i;
            end else begin
                m_bd = bus.is_branch_d_i;
                m_pc = m_pc + 4;
            end
        end
    endtask

    function automatic logic [31:0] rand_addr();
        int k;
        k = $urandom_range(0, 19);
        case (k)
            0: return 32'h0000_2FFC;
            1: return 32'h0000_7000;
            2: return 32'h0000_3000 + ($urandom_range(0, 4095) << 2) + 32'd2;
            3: return $urandom;
            default: return 32'h0000_3000 + ($urandom_range(0, 4095) << 2);
        endcase
    endfunction

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        stall, isb, taken, exc, eret;
        logic [31:0] target, epc;
        logic [31:0] e_addr, e_pcd;
        logic        e_bd, e_valid;
        logic [4:0]  e_exc;
    } vec_t;

    function automatic vec_t mk(input logic st, input logic isb, input logic tk,
                                input logic [31:0] tgt, input logic ex, input logic er,
                                input logic [31:0] epc, input logic [31:0] ea,
                                input logic [31:0] ep, input logic eb,
                                input logic ev, input logic [4:0] ee);
        vec_t v;
        v.stall = st; v.isb = isb; v.taken = tk; v.target = tgt; v.exc = ex;
        v.eret = er; v.epc = epc; v.e_addr = ea; v.e_pcd = ep; v.e_bd = eb;
        v.e_valid = ev; v.e_exc = ee;
        return v;
    endfunction

    localparam int c_NV = 24;
    vec_t tbl [c_NV];

    initial begin
        logic [31:0] ei;
        n_vec = 0;
        n_err = 0;
        //            st isb tk target        ex er epc           addr          pc_d          bd v exc
        tbl[0]  = mk(0, 0, 0, 32'h0,        0, 0, 32'h0,      32'h3004,   32'h3000,   0, 1, 0);
        tbl[1]  = mk(0, 0, 0, 32'h0,        0, 0, 32'h0,      32'h3008,   32'h3004,   0, 1, 0);
        tbl[2]  = mk(0, 0, 0, 32'h0,        0, 0, 32'h0,      32'h300C,   32'h3008,   0, 1, 0);
        tbl[3]  = mk(1, 0, 0, 32'h0,        0, 0, 32'h0,      32'h300C,   32'h3008,   0, 1, 0);
        tbl[4]  = mk(1, 1, 1, 32'h3500,     0, 0, 32'h0,      32'h300C,   32'h3008,   0, 1, 0);
        tbl[5]  = mk(0, 0, 0, 32'h0,        0, 0, 32'h0,      32'h3010,   32'h300C,   0, 1, 0);
        tbl[6]  = mk(0, 0, 0, 32'h0,        0, 0, 32'h0,      32'h3014,   32'h3010,   0, 1, 0);
        tbl[7]  = mk(0, 0, 0, 32'h0,        0, 0, 32'h0,      32'h3018,   32'h3014,   0, 1, 0);
        tbl[8]  = mk(0, 0, 0, 32'h0,        0, 0, 32'h0,      32'h301C,   32'h3018,   0, 1, 0);
        tbl[9]  = mk(0, 0, 0, 32'h0,        0, 0, 32'h0,      32'h3020,   32'h301C,   0, 1, 0);
        tbl[10] = mk(0, 1, 1, 32'h3100,     0, 0, 32'h0,      32'h3100,   32'h3020,   1, 1, 0);
        tbl[11] = mk(0, 1, 0, 32'h3300,     0, 0, 32'h0,      32'h3104,   32'h3100,   1, 1, 0);
        tbl[12] = mk(0, 0, 0, 32'h0,        0, 0, 32'h0,      32'h3108,   32'h3104,   0, 1, 0);
        tbl[13] = mk(1, 1, 1, 32'h3200,     1, 0, 32'h0,      32'h4180,   32'h0,      0, 0, 0);
        tbl[14] = mk(0, 0, 0, 32'h0,        0, 0, 32'h0,      32'h4184,   32'h4180,   0, 1, 0);
        tbl[15] = mk(0, 0, 0, 32'h0,        0, 1, 32'h3044,   32'h3044,   32'h0,      0, 0, 0);
        tbl[16] = mk(0, 0, 0, 32'h0,        0, 0, 32'h0,      32'h3048,   32'h3044,   0, 1, 0);
        tbl[17] = mk(0, 0, 0, 32'h0,        0, 1, 32'h3046,   32'h3046,   32'h0,      0, 0, 0);
        tbl[18] = mk(0, 0, 0, 32'h0,        0, 0, 32'h0,      32'h304A,   32'h3046,   0, 1, 4);
        tbl[19] = mk(0, 1, 1, 32'h2FFC,     0, 0, 32'h0,      32'h2FFC,   32'h304A,   1, 1, 4);
        tbl[20] = mk(0, 0, 0, 32'h0,        0, 0, 32'h0,      32'h3000,   32'h2FFC,   0, 1, 4);
        tbl[21] = mk(0, 1, 1, 32'h7000,     0, 0, 32'h0,      32'h7000,   32'h3000,   1, 1, 0);
        tbl[22] = mk(0, 0, 0, 32'h0,        0, 0, 32'h0,      32'h7004,   32'h7000,   0, 1, 4);
        tbl[23] = mk(0, 0, 0, 32'h0,        1, 1, 32'h3044,   32'h4180,   32'h0,      0, 0, 0);

        rst_n = 1'b0;
        drive(0, 0, 0, 32'h0, 0, 0, 32'h0);
        repeat (2) @(negedge clk);
        check_outs("reset", 32'h3000, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0);
        rst_n = 1'b1;

        for (int i = 0; i < c_NV; i++) begin
            drive(tbl[i].stall, tbl[i].isb, tbl[i].taken, tbl[i].target,
                  tbl[i].exc, tbl[i].eret, tbl[i].epc);
            @(posedge clk);
            #1;
            ei = (tbl[i].e_valid && tbl[i].e_exc == 5'd0) ? imem_word(tbl[i].e_pcd) : 32'h0;
            check_outs($sformatf("vec%0d", i), tbl[i].e_addr, ei, tbl[i].e_pcd,
                       tbl[i].e_bd, tbl[i].e_exc, tbl[i].e_valid);
            @(negedge clk);
        end

        // Reset asserted in the middle of a stall: outputs drop with no edge.
        drive(0, 0, 0, 32'h0, 0, 0, 32'h0);
        @(posedge clk); #1;
        @(negedge clk);
        drive(1, 1, 1, 32'h3800, 0, 0, 32'h0);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check_outs("rst_mid_stall", 32'h3000, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0);
        @(posedge clk); #1;
        check_outs("rst_held", 32'h3000, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0);
        @(negedge clk);
        drive(0, 0, 0, 32'h0, 0, 0, 32'h0);
        rst_n = 1'b1;
        model_reset();

        // Random phase against the behavioural model.
        for (int c = 0; c < 600; c++) begin
            int r;
            logic isb;
            r   = $urandom_range(0, 99);
            isb = ($urandom_range(0, 2) == 0);
            drive(($urandom_range(0, 3) == 0), isb, isb && ($urandom_range(0, 1) == 1),
                  rand_addr(), (r < 3), (r >= 3 && r < 6), rand_addr());
            model_step();
            @(posedge clk);
            #1;
            check_outs("rnd", m_pc, m_instr, m_pcd, m_bd, m_exc, m_valid);
            @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
